// File: rtl/riscv_mc_pkg.sv
// Purpose: shared types and encodings for the multicycle RV32I main control FSM.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
// Contents: state enum, opcode constants, mux/ALUOp encodings, control struct,
//           next-state and per-state output decode functions.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_JAL      = 4'd8,
      S_ALUWB    = 4'd9,
      S_BEQ      = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Everything the FSM registers per state. pc_update and branch are
   // internal; they only reach the outside world merged into PCWrite.
   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   // Next state. Any encoding outside the defined set lands in HALT.
   function automatic state_t fsm_next(input state_t s, input logic [6:0] op);
      state_t n;
      n = S_HALT;
      case (s)
         S_FETCH:    n = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: n = S_MEMADR;
               OP_R:         n = S_EXECR;
               OP_I:         n = S_EXECI;
               OP_JAL:       n = S_JAL;
               OP_BEQ:       n = S_BEQ;
               default:      n = S_HALT;
            endcase
         end
         S_MEMADR:   n = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  n = S_MEMWB;
         S_MEMWB:    n = S_FETCH;
         S_MEMWRITE: n = S_FETCH;
         S_EXECR:    n = S_ALUWB;
         S_EXECI:    n = S_ALUWB;
         S_JAL:      n = S_ALUWB;
         S_ALUWB:    n = S_FETCH;
         S_BEQ:      n = S_FETCH;
         S_HALT:     n = S_HALT;
         default:    n = S_HALT;
      endcase
      return n;
   endfunction

   // Moore output decode; fields not named for a state stay 0.
   function automatic ctrl_t fsm_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALURESULT;
            c.pc_update  = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
            c.mem_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_REG;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_JAL: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALUOUT;
            c.pc_update  = 1'b1;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a  = SRCA_RS1;
            c.alu_src_b  = SRCB_REG;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
            c.branch     = 1'b1;
            c.instr_done = 1'b1;
         end
         default: begin
            c.illegal_op = 1'b1;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Purpose: bundle of the FSM's datapath-facing signals (opcode/flag in, controls out).
// Latency: n/a (wires only).
// Backpressure: none; controls are level signals consumed every cycle.
// Modports: master = control FSM (reads op/Zero, drives controls);
//           slave  = datapath side (drives op/Zero, reads controls).
interface multicycle_main_fsm_if;
   logic [6:0] op;
   logic       Zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] ImmSrc;
   logic       instr_done;
   logic       illegal_op;

   modport master (
      input  op, Zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal_op
   );

   modport slave (
      output op, Zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal_op
   );
endinterface

// File: rtl/imm_src_decoder.sv
// Purpose: maps the opcode to the immediate format select for the extender.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: op (Instr[6:0]) in, imm_src (00 I, 01 S, 10 B, 11 J) out.
module imm_src_decoder
   import riscv_mc_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] imm_src
);

   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Purpose: main sequencer of the multicycle RV32I core; drives all datapath enables/selects.
// Latency: 3-5 cycles per instruction (beq 3; sw/R/I/jal 4; lw 5), FETCH to FETCH.
// Backpressure: none; the FSM free-runs and stops only in HALT on an illegal opcode.
// Ports: clk, reset (async, active-high); bus (master) carries op/Zero in and
//        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA/B,
//        ALUOp, ImmSrc, instr_done, illegal_op out.
module multicycle_main_fsm
   import riscv_mc_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   multicycle_main_fsm_if.master bus
);

   state_t     state;
   ctrl_t      ctrl;
   logic [1:0] imm_src;

   // Outputs are registered from the next state, so ctrl always equals
   // fsm_ctrl(state). Reset loads FETCH controls together with the state, so
   // the async assertion also kills RegWrite/MemWrite immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         ctrl  <= fsm_ctrl(S_FETCH);
      end else begin
         state <= fsm_next(state, bus.op);
         ctrl  <= fsm_ctrl(fsm_next(state, bus.op));
      end
   end

   imm_src_decoder u_imm_src_decoder (
      .op      (bus.op),
      .imm_src (imm_src)
   );

   // Zero only matters in BEQ, the one state with branch set.
   assign bus.PCWrite    = ctrl.pc_update | (ctrl.branch & bus.Zero);
   assign bus.AdrSrc     = ctrl.adr_src;
   assign bus.MemWrite   = ctrl.mem_write;
   assign bus.IRWrite    = ctrl.ir_write;
   assign bus.RegWrite   = ctrl.reg_write;
   assign bus.ResultSrc  = ctrl.result_src;
   assign bus.ALUSrcA    = ctrl.alu_src_a;
   assign bus.ALUSrcB    = ctrl.alu_src_b;
   assign bus.ALUOp      = ctrl.alu_op;
   assign bus.ImmSrc     = imm_src;
   assign bus.instr_done = ctrl.instr_done;
   assign bus.illegal_op = ctrl.illegal_op;

endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Main control state machine for the multicycle RV32I core. Sits directly upstream of the ALU decoder: it sequences each instruction over 3–5 cycles and drives `ALUOp`, which the ALU decoder combines with `funct3`/`funct7_5`/`op_5` to produce `ALUControl`. It also drives every datapath enable and mux select for the shared-memory multicycle datapath.

## Interface
- No parameters.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 7: `Instr[6:0]` from the instruction register.
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction/OldPC register enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = rs1 register A.
- `ALUSrcB` out 2: 00 = register B, 01 = ImmExt, 10 = constant 4.
- `ALUOp` out 2: 00 = add, 01 = subtract (branch), 10 = decode by funct.
- `ImmSrc` out 2: 00 = I-type, 01 = S-type, 10 = B-type, 11 = J-type.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal_op` out 1: high while halted on an unsupported opcode.

## Operation
- Moore FSM. Outputs other than `ImmSrc` and `PCWrite` are functions of the state register only. `PCWrite = PCUpdate | (Branch & Zero)`.
- `ImmSrc` is combinational from `op`: 0000011/0010011 → 00, 0100011 → 01, 1100011 → 10, 1101111 → 11, others → 00.
- Unlisted outputs in each state below are 0.
- States and outputs:
  - FETCH: `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10, PCUpdate=1. Next: DECODE.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00.
    - Next by `op`: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1101111 → JAL; 1100011 → BEQ; any other → HALT.
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. Next: MEMREAD if `op`=0000011, else MEMWRITE.
  - MEMREAD: `ResultSrc`=00, `AdrSrc`=1. Next: MEMWB.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1, `instr_done`=1. Next: FETCH.
  - MEMWRITE: `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1, `instr_done`=1. Next: FETCH.
  - EXECR: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10. Next: ALUWB.
  - EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10. Next: ALUWB.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, PCUpdate=1. Next: ALUWB.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1, `instr_done`=1. Next: FETCH.
  - BEQ: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, Branch=1, `instr_done`=1. Next: FETCH.
  - HALT: all enables 0, `illegal_op`=1. Stays in HALT until `reset`.
- Every unreachable state encoding goes to HALT.

## Timing
- Reset:
  - `reset` forces the state to FETCH immediately, without waiting for a clock edge. The state is held there while `reset` is high.
  - Outputs during reset are the FETCH values: `IRWrite`=1, `PCWrite`=1, `ALUSrcB`=10, `ResultSrc`=10. All other outputs are 0 (`ImmSrc` follows `op`).
  - The datapath registers share `reset`, so these enables have no effect.
- The first FETCH executes on the first rising edge after `reset` deasserts.
- Latency in cycles, from FETCH to the return to FETCH: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3.
- `Zero` is sampled combinationally only in BEQ. A taken branch asserts `PCWrite` in the BEQ cycle. A not-taken branch never asserts `PCWrite` in that instruction after FETCH.
- `op` must be stable from the end of FETCH onward, because the IR is written at the FETCH edge. DECODE and MEMADR branch on the registered IR.
- `reset` asserted mid-instruction (including in HALT) aborts the instruction. No further `RegWrite`/`MemWrite` is issued after assertion.

## Structure
- Shared package `riscv_mc_pkg` holds:
  - state enum
  - opcode constants (`OP_LW`, `OP_SW`, `OP_R`, `OP_I`, `OP_BEQ`, `OP_JAL`)
  - `ALUOp` encodings
  - `ResultSrc`/`ALUSrcA`/`ALUSrcB`/`ImmSrc` encodings
- One sub-module, `imm_src_decoder`: the combinational `op` → `ImmSrc` mapping. The FSM, next-state logic and output decode stay in this module.

## Test plan
- lw: release `reset`, `op`=0000011.
  - State sequence: FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - `AdrSrc`=1 in cycle 4; `RegWrite`=1 and `ResultSrc`=01 in cycle 5.
  - `instr_done` pulses only in cycle 5; FETCH in cycle 6.
- sw, `op`=0100011: 4 cycles. `MemWrite`=1 only in cycle 4; `ImmSrc`=01; `RegWrite` never 1.
- R-type then I-type ALU:
  - `op`=0110011 gives `ALUOp`=10 with `ALUSrcB`=00 in cycle 3.
  - `op`=0010011 gives `ALUOp`=10 with `ALUSrcB`=01 in cycle 3.
  - Both give `RegWrite`=1 in cycle 4.
- beq, `op`=1100011:
  - With `Zero`=1: `PCWrite`=1 and `ALUOp`=01 in cycle 3.
  - Repeat with `Zero`=0: `PCWrite`=0 in cycle 3.
  - FETCH follows in both cases.
- jal, `op`=1101111: `PCWrite`=1 in cycle 3 with `ALUSrcA`=01, `ALUSrcB`=10; `RegWrite`=1 in cycle 4; `ImmSrc`=11.
- Illegal opcode and reset:
  - `op`=0000000 enters HALT after DECODE; `illegal_op`=1 with all enables 0 for 10+ cycles.
  - Async `reset` pulsed mid-cycle returns the FSM to FETCH before the next edge.
  - Separately, `reset` asserted in MEMADR of a sw must never produce `MemWrite`=1.
